// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon message loader.
package ascon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } loader_state_t;

    localparam logic [7:0] PAD_BYTE   = 8'h80;
    localparam int         MAX_BLOCKS = 4;
    localparam logic [1:0] LAST_INDEX = 2'(MAX_BLOCKS - 1);

endpackage

// File: rtl/ascon_data_loader_if.sv
// Byte-in / block-out bundle between the message source, the loader and the core.
// Byte side: a byte moves on a rising edge where i_byte_valid, o_byte_ready and i_sys_enable are all 1;
// block side: o_data is offered while o_data_valid=1 and is consumed by a one-cycle i_data_ack pulse.
interface ascon_data_loader_if;
    import ascon_pkg::*;

    logic          i_sys_enable;
    logic [7:0]    i_byte;
    logic          i_byte_valid;
    logic          i_byte_last;
    logic          o_byte_ready;
    logic [63:0]   o_data;
    logic          o_data_valid;
    logic          i_data_ack;
    logic          o_start;
    logic [1:0]    o_block_index;
    logic          o_last_block;
    logic          o_error;
    loader_state_t dbg_state;

    modport slave (
        input  i_sys_enable, i_byte, i_byte_valid, i_byte_last, i_data_ack,
        output o_byte_ready, o_data, o_data_valid, o_start, o_block_index,
               o_last_block, o_error, dbg_state
    );

    modport master (
        output i_sys_enable, i_byte, i_byte_valid, i_byte_last, i_data_ack,
        input  o_byte_ready, o_data, o_data_valid, o_start, o_block_index,
               o_last_block, o_error, dbg_state
    );

endinterface

// File: rtl/ascon_data_loader.sv
// Packs a byte stream big-endian into 64-bit blocks for the Ascon core, at most four per message.
// Define ASCON_LOADER_PAD_EN to append the 0x80 pad byte (and an extra pad block on 8-byte boundaries).
module ascon_data_loader
    import ascon_pkg::*;
(
    input logic                clock,
    input logic                reset,
    ascon_data_loader_if.slave bus
);

`ifdef ASCON_LOADER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    loader_state_t state;
    logic [63:0]   data_q;
    logic [2:0]    byte_pos;
    logic [1:0]    block_index;
    logic          last_block;
    logic          data_valid;
    logic          start;
    logic          error;
    logic          pad_pending;

    logic          ready_int;
    logic          block_done;
    logic          full_last;
    logic [5:0]    shift;
    logic [63:0]   data_next;

    assign ready_int  = (state == ST_IDLE) || (state == ST_FILL);
    assign block_done = (byte_pos == 3'd7) || bus.i_byte_last;
    assign full_last  = bus.i_byte_last && (byte_pos == 3'd7);
    assign shift      = {~byte_pos, 3'b000};

    // The first byte of a block clears the rest, which gives the zero fill for free.
    always_comb begin
        data_next = (byte_pos == 3'd0) ? 64'd0 : data_q;
        data_next = data_next | ({56'd0, bus.i_byte} << shift);
        if (PAD_EN && bus.i_byte_last && (byte_pos != 3'd7))
            data_next = data_next | (({56'd0, PAD_BYTE} << shift) >> 8);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            data_q      <= '0;
            byte_pos    <= '0;
            block_index <= '0;
            last_block  <= 1'b0;
            data_valid  <= 1'b0;
            start       <= 1'b0;
            error       <= 1'b0;
            pad_pending <= 1'b0;
        end else if (bus.i_sys_enable) begin
            start <= 1'b0;
            case (state)
                ST_IDLE, ST_FILL: begin
                    if (bus.i_byte_valid) begin
                        data_q   <= data_next;
                        byte_pos <= byte_pos + 3'd1;
                        state    <= ST_FILL;
                        if (state == ST_IDLE) begin
                            start       <= 1'b1;
                            block_index <= '0;
                            last_block  <= 1'b0;
                            pad_pending <= 1'b0;
                        end
                        if (block_done) begin
                            state       <= ST_HOLD;
                            data_valid  <= 1'b1;
                            byte_pos    <= '0;
                            // A message filling its block exactly defers "last" to the pad block.
                            last_block  <= bus.i_byte_last && !(PAD_EN && full_last);
                            pad_pending <= PAD_EN && full_last;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.i_data_ack) begin
                        if (pad_pending && (block_index != LAST_INDEX)) begin
                            pad_pending <= 1'b0;
                            data_q      <= {PAD_BYTE, 56'd0};
                            block_index <= block_index + 2'd1;
                            last_block  <= 1'b1;
                        end else if (last_block && !pad_pending) begin
                            state      <= ST_IDLE;
                            data_valid <= 1'b0;
                            if (block_index != LAST_INDEX)
                                block_index <= block_index + 2'd1;
                        end else if (block_index == LAST_INDEX) begin
                            // More data (or a pad block) would need a fifth block.
                            state       <= ST_ERROR;
                            data_valid  <= 1'b0;
                            error       <= 1'b1;
                            pad_pending <= 1'b0;
                        end else begin
                            state       <= ST_FILL;
                            data_valid  <= 1'b0;
                            block_index <= block_index + 2'd1;
                        end
                    end
                end
                ST_ERROR: state <= ST_ERROR;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_byte_ready  = ready_int && bus.i_sys_enable;
    assign bus.o_data        = data_q;
    assign bus.o_data_valid  = data_valid;
    assign bus.o_start       = start;
    assign bus.o_block_index = block_index;
    assign bus.o_last_block  = last_block;
    assign bus.o_error       = error;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_ascon_data_loader.sv
// Randomised bench for ascon_data_loader: a message-level block model feeds an expected queue.
// Follows ASCON_LOADER_PAD_EN the same way the design does.
module tb_ascon_data_loader;
    import ascon_pkg::*;

    localparam int W = 68;  // {err_after, last, index[1:0], data[63:0]}

    logic clock = 1'b0;
    logic reset = 1'b1;

    ascon_data_loader_if bus ();

    ascon_data_loader dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q[$];
    logic [7:0]   msg_bytes[64];
    bit           model_err;
    bit           exp_start, exp_error, prev_valid, prev_hs;
    logic [66:0]  held;
    bit           drv_first = 1'b0;
    bit           en_rand   = 1'b0;
    bit           checking  = 1'b0;
    int           ack_min   = 0;
    int           ack_wait  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Message-level model: slice into 8-byte chunks, zero fill, optional pad, at most four blocks.
    task automatic model_msg(input int n, input bit term);
        logic [63:0]  blk;
        logic [W-1:0] item;
        int nblk, total, p;
        bit pad_blk;
        model_q.delete();
        nblk    = (n + 7) / 8;
        pad_blk = 1'b0;
`ifdef ASCON_LOADER_PAD_EN
        if (term && (n % 8 == 0)) pad_blk = 1'b1;
`endif
        total     = nblk + int'(pad_blk);
        model_err = (total > 4) || !term;
        for (int b = 0; b < total && b < 4; b++) begin
            blk = '0;
            for (int k = 0; k < 8; k++) begin
                p = b * 8 + k;
                if (p < n) blk[63 - 8*k -: 8] = msg_bytes[p];
`ifdef ASCON_LOADER_PAD_EN
                else if (p == n && term) blk[63 - 8*k -: 8] = 8'h80;
`endif
            end
            item = {(b == 3) && model_err, term && (b == total - 1) && (total <= 4), 2'(b), blk};
            model_q.push_back(item);
        end
    endtask

    task automatic push_model();
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            bus.i_byte_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input bit first,
                             input int budget, output bit acc);
        @(posedge clock); #1;
        bus.i_byte       = b;
        bus.i_byte_last  = last;
        bus.i_byte_valid = 1'b1;
        drv_first        = first;
        acc              = 1'b0;
        for (int t = 0; t < budget && !acc; t++) begin
            @(negedge clock);
            if (bus.o_byte_ready) acc = 1'b1;
        end
    endtask

    task automatic send_msg(input int n, input bit term, input int n_drive, input bit gaps);
        bit acc;
        for (int i = 0; i < n_drive; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
            send_byte(msg_bytes[i], term && (i == n - 1), i == 0, 400, acc);
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("FAIL byte_accept: byte %0d got no acceptance, expected acceptance within 400 cycles", i);
                break;
            end
        end
        gap(1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.o_data_valid) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d blocks outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset            = 1'b1;
        bus.i_byte_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Ack source: random delay of at least ack_min cycles, plus stray acks while nothing is offered.
    initial begin
        bus.i_data_ack = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (reset || !bus.o_data_valid) begin
                bus.i_data_ack = ($urandom_range(0, 7) == 0);
                ack_wait       = 0;
            end else if (bus.i_data_ack) begin
                bus.i_data_ack = 1'b0;
                ack_wait       = 0;
            end else begin
                if (ack_wait >= ack_min && $urandom_range(0, 2) == 0) bus.i_data_ack = 1'b1;
                ack_wait++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock); #1;
            if (en_rand) bus.i_sys_enable = ($urandom_range(0, 5) != 0);
        end
    end

    // Scoreboard / per-cycle compare.
    always @(negedge clock) begin
        logic [W-1:0] item;
        logic hs, bhs;
        if (reset || !checking) begin
            exp_start  = 1'b0;
            exp_error  = 1'b0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            hs  = bus.o_data_valid && bus.i_data_ack && bus.i_sys_enable;
            bhs = bus.i_byte_valid && bus.o_byte_ready;
            check("start", W'(bus.o_start), W'(exp_start));
            check("error", W'(bus.o_error), W'(exp_error));
            check("byte_ready", W'(bus.o_byte_ready),
                  W'(bus.i_sys_enable && !bus.o_data_valid && !exp_error));
            if (exp_error) check("valid_in_error", W'(bus.o_data_valid), '0);
            if (bus.o_data_valid && prev_valid && !prev_hs)
                check("hold_stable", W'({bus.o_last_block, bus.o_block_index, bus.o_data}), W'(held));
            if (hs) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_block: got %h expected no block", bus.o_data);
                end else begin
                    item = exp_q.pop_front();
                    check("block", W'({bus.o_last_block, bus.o_block_index, bus.o_data}), W'(item[66:0]));
                    if (item[67]) exp_error = 1'b1;
                end
            end
            held       = {bus.o_last_block, bus.o_block_index, bus.o_data};
            prev_valid = bus.o_data_valid;
            prev_hs    = hs;
            if (bus.i_sys_enable) exp_start = bhs && drv_first;
        end
    end

    initial begin
        logic [W-1:0] it;
        bit acc;
        bus.i_sys_enable = 1'b1;
        bus.i_byte       = '0;
        bus.i_byte_valid = 1'b0;
        bus.i_byte_last  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset    = 1'b0;
        checking = 1'b1;
        @(negedge clock);
        check("rst_data", W'(bus.o_data), '0);
        check("rst_valid", W'(bus.o_data_valid), '0);
        check("rst_index", W'(bus.o_block_index), '0);
        check("rst_last", W'(bus.o_last_block), '0);
        check("rst_ready", W'(bus.o_byte_ready), W'(1));

        // 0x01..0x08 ending on the eighth byte
        for (int i = 0; i < 8; i++) msg_bytes[i] = 8'(i + 1);
        model_msg(8, 1'b1);
        it = model_q[0];
        check("model_t1_data", W'(it[63:0]), W'(64'h0102030405060708));
        check("model_t1_index", W'(it[65:64]), '0);
`ifdef ASCON_LOADER_PAD_EN
        check("model_t1_last", W'(it[66]), '0);
        check("model_t1_count", W'(model_q.size()), W'(2));
`else
        check("model_t1_last", W'(it[66]), W'(1));
        check("model_t1_count", W'(model_q.size()), W'(1));
`endif
        push_model();
        send_msg(8, 1'b1, 8, 1'b0);
        wait_drain();

        // three-byte partial block
        msg_bytes[0] = 8'hAA; msg_bytes[1] = 8'hBB; msg_bytes[2] = 8'hCC;
        model_msg(3, 1'b1);
        it = model_q[0];
`ifdef ASCON_LOADER_PAD_EN
        check("model_t2_data", W'(it[63:0]), W'(64'hAABBCC8000000000));
`else
        check("model_t2_data", W'(it[63:0]), W'(64'hAABBCC0000000000));
`endif
        check("model_t2_last", W'(it[66]), W'(1));
        push_model();
        send_msg(3, 1'b1, 3, 1'b0);
        wait_drain();

        // sixteen bytes, boundary-aligned end
        for (int i = 0; i < 16; i++) msg_bytes[i] = 8'(i * 17 + 3);
        model_msg(16, 1'b1);
`ifdef ASCON_LOADER_PAD_EN
        check("model_t3_count", W'(model_q.size()), W'(3));
        it = model_q[2];
        check("model_t3_pad", W'(it), W'({1'b0, 1'b1, 2'd2, 64'h8000000000000000}));
`else
        check("model_t3_count", W'(model_q.size()), W'(2));
        it = model_q[1];
        check("model_t3_last", W'({it[66], it[65:64]}), W'({1'b1, 2'd1}));
`endif
        push_model();
        send_msg(16, 1'b1, 16, 1'b0);
        wait_drain();

        // slow ack with a two-cycle enable drop while the block is held and more bytes wait
        ack_min = 6;
        for (int i = 0; i < 8; i++) msg_bytes[i] = 8'($urandom_range(0, 255));
        model_msg(8, 1'b1);
        push_model();
        model_msg(2, 1'b1);
        push_model();
        fork
            begin
                send_msg(8, 1'b1, 8, 1'b0);
                send_msg(2, 1'b1, 2, 1'b0);
            end
            begin
                int t;
                t = 0;
                while (!bus.o_data_valid && t < 200) begin
                    @(negedge clock);
                    t++;
                end
                @(posedge clock); #1;
                bus.i_sys_enable = 1'b0;
                repeat (2) @(posedge clock);
                #1;
                bus.i_sys_enable = 1'b1;
            end
        join
        wait_drain();
        ack_min = 0;

        // random traffic with random enable gaps
        en_rand = 1'b1;
        for (int m = 0; m < 40; m++) begin
            int n;
            n = $urandom_range(1, 32);
            for (int i = 0; i < n; i++) msg_bytes[i] = 8'($urandom_range(0, 255));
            model_msg(n, 1'b1);
            push_model();
            send_msg(n, 1'b1, n, 1'b1);
            if (model_err) begin
                wait_drain();
                do_reset();
            end
        end
        wait_drain();
        en_rand          = 1'b0;
        bus.i_sys_enable = 1'b1;

        // 33 bytes without a last marker: four blocks, then the error state
        for (int i = 0; i < 33; i++) msg_bytes[i] = 8'($urandom_range(0, 255));
        model_msg(33, 1'b0);
        check("model_t4_count", W'(model_q.size()), W'(4));
        it = model_q[3];
        check("model_t4_err", W'(it[67]), W'(1));
        push_model();
        send_msg(33, 1'b0, 32, 1'b0);
        send_byte(msg_bytes[32], 1'b0, 1'b0, 60, acc);
        check("byte33_refused", W'(acc), '0);
        gap(1);
        wait_drain();
        @(negedge clock);
        check("overflow_error", W'(bus.o_error), W'(1));
        check("overflow_ready", W'(bus.o_byte_ready), '0);
        do_reset();

        // reset after five bytes, then a fresh two-byte message
        for (int i = 0; i < 5; i++) msg_bytes[i] = 8'($urandom_range(1, 255));
        send_msg(5, 1'b0, 5, 1'b0);
        do_reset();
        @(negedge clock);
        check("midrst_data", W'(bus.o_data), '0);
        check("midrst_valid", W'(bus.o_data_valid), '0);
        check("midrst_start", W'(bus.o_start), '0);
        check("midrst_index", W'(bus.o_block_index), '0);
        check("midrst_last", W'(bus.o_last_block), '0);
        check("midrst_error", W'(bus.o_error), '0);
        msg_bytes[0] = 8'h5A; msg_bytes[1] = 8'hC3;
        model_msg(2, 1'b1);
        it = model_q[0];
`ifdef ASCON_LOADER_PAD_EN
        check("model_t5_block", W'(it), W'({1'b0, 1'b1, 2'd0, 64'h5AC3800000000000}));
`else
        check("model_t5_block", W'(it), W'({1'b0, 1'b1, 2'd0, 64'h5AC3000000000000}));
`endif
        push_model();
        send_msg(2, 1'b1, 2, 1'b0);
        wait_drain();

        repeat (3) @(negedge clock);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ascon_data_loader.md
ASCON_DATA_LOADER -- requirements
Module: ascon_data_loader

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: i_sys_enable  in  1  global enable, active high.
REQ-004 SHALL have ports: i_byte  in  8  message byte; i_byte_valid  in  1  byte valid; i_byte_last  in  1  final byte of message.
REQ-005 SHALL have ports: o_byte_ready  out  1  loader can accept a byte.
REQ-006 SHALL have ports: o_data  out  64  packed block to core i_data; o_data_valid  out  1  block valid, drives core i_data_valid.
REQ-007 SHALL have ports: i_data_ack  in  1  core consumed current block (one-cycle pulse).
REQ-008 SHALL have ports: o_start  out  1  one-cycle pulse, drives core i_start; o_block_index  out  2  index of presented block; o_last_block  out  1  presented block is final; o_error  out  1  sticky overflow flag.

Function
REQ-009 SHALL transfer a byte only in a cycle with i_byte_valid=1, o_byte_ready=1 and i_sys_enable=1.
REQ-010 SHALL pack bytes big-endian: the first byte of a block goes to o_data[63:56], the eighth byte to o_data[7:0].
REQ-011 SHALL implement states IDLE, FILL, HOLD and ERROR, with o_byte_ready=1 only in IDLE and FILL.
REQ-012 SHALL, on acceptance of the first byte of a message in IDLE, pulse o_start for exactly one cycle and go to FILL.
REQ-013 SHALL move to HOLD when the eighth byte or the byte with i_byte_last is accepted, and SHALL assert o_data_valid on the following cycle (latency 1 cycle).
REQ-014 SHALL hold o_data, o_block_index and o_last_block stable while o_data_valid=1.
REQ-015 SHALL, on i_data_ack in HOLD, deassert o_data_valid on the next cycle, increment the block index, and go to FILL (or IDLE if o_last_block=1).
REQ-016 SHALL ignore i_data_ack while o_data_valid=0.
REQ-017 SHALL zero-fill unused bytes of a partial final block.
REQ-018 SHALL set o_block_index to 0 for the first block of each message and SHALL wrap it from 3 to 0 only at message start.
REQ-019 SHALL, if a fifth block would be needed, set o_error=1 without presenting that block, enter ERROR with o_byte_ready=0, and remain there until reset; this includes the padding block of REQ-025.
REQ-020 SHALL freeze all registers while i_sys_enable=0 and force o_byte_ready=0 combinationally; o_start and o_data_valid SHALL retain their register values.

Reset
REQ-021 SHALL, while reset=1 at a rising edge, set state to IDLE and clear o_data, o_data_valid, o_start, o_block_index, o_last_block, o_error and byte position.
REQ-022 SHALL let reset take priority over i_sys_enable and any handshake.
REQ-023 SHALL discard any partially filled block on reset mid-operation.

Configuration
REQ-024 SHALL, with ASCON_LOADER_PAD_EN defined, write pad byte 0x80 at the first unused byte position of a partial final block.
REQ-025 SHALL, with ASCON_LOADER_PAD_EN defined and a message ending on an 8-byte boundary, present an extra final block 64'h8000_0000_0000_0000 directly after the ack of the full block.
REQ-026 SHALL, without ASCON_LOADER_PAD_EN, apply zero-fill only and present no extra block.

Structure
REQ-027 SHALL place the loader state enum, constant PAD_BYTE=8'h80 and constant MAX_BLOCKS=4 in ascon_pkg.
REQ-028 SHALL be a single module with no sub-module.

Verification
REQ-029 Bench SHALL cover: 8 bytes 0x01..0x08, last on 8th, no PAD_EN -> o_start pulse; one block 64'h0102030405060708 with o_last_block=1 and index 0.
REQ-030 Bench SHALL cover: 3 bytes 0xAA,0xBB,0xCC with PAD_EN -> block 64'hAABBCC8000000000 with last=1.
REQ-031 Bench SHALL cover: 16 bytes with PAD_EN -> blocks with index 0, 1, 2; the third block is 64'h8000000000000000 with last=1.
REQ-032 Bench SHALL cover: 33 bytes with no last by byte 32 -> four blocks, then o_error=1 and o_byte_ready=0.
REQ-033 Bench SHALL cover: i_data_ack delayed 5 cycles plus i_sys_enable low for 2 cycles -> o_data stable and no byte accepted meanwhile.
REQ-034 Bench SHALL cover: reset asserted after 5 bytes -> all outputs 0 next cycle; a new 2-byte message yields index 0.
